game_event_controller: RTL and testbench

GAME_EVENT_CONTROLLER -- requirements
Module: game_event_controller

---
 rtl/game_event_controller.sv | 171 +++++++++++++++++
 tb/tb_game_event_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_event_controller.sv
// Game event controller: debounced key presses and periodic frame ticks are coalesced
// into per-source pending bits and queued as interrupt instruction words for the CPU.
module game_event_controller #(
    parameter int         NUM_KEYS        = 2,
    parameter int         SYS_FREQ        = 100000000,
    parameter int         FRAME_RATE      = 60,
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [4:0] OPCODE          = 5'b10110
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_KEYS-1:0]           keys,
    input  logic                          game_enable,
    input  logic                          int_ack,
    output logic [31:0]                   interrupt_instruction,
    output logic                          int_valid,
    output logic                          frame_tick,
    output logic [NUM_KEYS-1:0]           key_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int FRAME_PERIOD = ((SYS_FREQ / FRAME_RATE) < 1) ? 1 : (SYS_FREQ / FRAME_RATE);
    localparam int FC_W         = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int DB_W         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int NUM_SRC      = NUM_KEYS + 1;

    localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(FRAME_PERIOD - 1);
    localparam logic [DB_W-1:0]  DB_LIMIT   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] key_prev_q, key_prev_d;
    logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
    logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];

    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic                overflow_q, overflow_d;

    logic [7:0]          fifo_mem_q [FIFO_DEPTH];
    logic [7:0]          fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [NUM_SRC-1:0]  src_event;
    logic [NUM_SRC-1:0]  grant_oh;
    logic [7:0]          grant_id;
    logic                grant_valid;
    logic                pop;
    logic                full;
    logic                enq;

    always_comb begin
        sync1_d     = keys;
        sync2_d     = sync1_q;
        key_state_d = key_state_q;
        key_prev_d  = key_state_q;
        db_cnt_d    = db_cnt_q;

        // Counter tracks consecutive disagreeing cycles; the toggle fires on the cycle it would reach the limit.
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (sync2_q[k] != key_state_q[k]) begin
                if (db_cnt_q[k] == DB_LIMIT - 1'b1) begin
                    key_state_d[k] = ~key_state_q[k];
                    db_cnt_d[k]    = '0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end else begin
                db_cnt_d[k] = '0;
            end
        end

        frame_tick = game_enable && (frame_cnt_q == FRAME_LAST);
        if (!game_enable || (frame_cnt_q == FRAME_LAST)) begin
            frame_cnt_d = '0;
        end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        src_event    = '0;
        src_event[0] = frame_tick;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            src_event[k+1] = game_enable && key_state_q[k] && !key_prev_q[k];
        end

        pop  = int_ack && (count_q != '0);
        full = (count_q == FIFO_FULL);

        grant_valid = 1'b0;
        grant_id    = '0;
        grant_oh    = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (pending_q[s] && !grant_valid) begin
                grant_valid = 1'b1;
                grant_id    = 8'(s);
                grant_oh[s] = 1'b1;
            end
        end

        // A pop in the same cycle frees the slot needed to accept the winner.
        enq = grant_valid && (!full || pop);
        if (!enq) begin
            grant_oh = '0;
        end

        pending_d  = (pending_q & ~grant_oh) | src_event;
        overflow_d = overflow_q || (full && !pop && (|(src_event & pending_q)));

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (enq) begin
            fifo_mem_d[wr_ptr_q] = grant_id;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            key_state_q <= '0;
            key_prev_q  <= '0;
            db_cnt_q    <= '{default: '0};
            frame_cnt_q <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            fifo_mem_q  <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_state_q <= key_state_d;
            key_prev_q  <= key_prev_d;
            db_cnt_q    <= db_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            fifo_mem_q  <= fifo_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign int_valid             = (count_q != '0);
    assign interrupt_instruction = int_valid ? {OPCODE, 3'b000, fifo_mem_q[rd_ptr_q], 16'h0000} : 32'd0;
    assign key_state             = key_state_q;
    assign fifo_count            = count_q;
    assign overflow              = overflow_q;

endmodule

// File: tb/tb_game_event_controller.sv
// Bench for game_event_controller: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based behavioural model of the event rules.
module tb_game_event_controller;

    localparam int NK    = 2;
    localparam int P     = 10;
    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys = '0;
    logic          game_enable = 1'b0;
    logic          int_ack = 1'b0;
    logic [31:0]   interrupt_instruction;
    logic          int_valid;
    logic          frame_tick;
    logic [NK-1:0] key_state;
    logic [2:0]    fifo_count;
    logic          overflow;

    always #5 clk = ~clk;

    game_event_controller #(
        .NUM_KEYS(NK),
        .SYS_FREQ(100),
        .FRAME_RATE(10),
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH(DEPTH),
        .OPCODE(5'b10110)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys(keys),
        .game_enable(game_enable),
        .int_ack(int_ack),
        .interrupt_instruction(interrupt_instruction),
        .int_valid(int_valid),
        .frame_tick(frame_tick),
        .key_state(key_state),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: raw keys seen two cycles late, debounced by stable-run length,
    // frame ticks from cycles-since-enable, and the event queue as a plain SV queue.
    bit [NK-1:0] m_s1, m_s2, m_ks, m_prev;
    int          m_run [NK];
    int          m_n;
    bit [NK:0]   m_pend;
    int          m_q [$];
    bit          m_ovf;

    function automatic logic [31:0] word_of(input int id);
        return 32'hB000_0000 | (32'(id) << 16);
    endfunction

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_ks = '0; m_prev = '0;
        for (int k = 0; k < NK; k++) m_run[k] = 0;
        m_n = 0; m_pend = '0; m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic model_edge();
        bit [NK:0] ev;
        bit        tick;
        bit        pop;
        int        sz;
        if (reset) begin
            m_reset();
            return;
        end
        tick  = game_enable && (m_n % P == P - 1);
        ev    = '0;
        ev[0] = tick;
        for (int k = 0; k < NK; k++) ev[k+1] = game_enable && m_ks[k] && !m_prev[k];
        sz  = m_q.size();
        pop = int_ack && (sz > 0);
        if (sz == DEPTH && !pop && (|(ev & m_pend))) m_ovf = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (sz - int'(pop) < DEPTH) begin
            for (int s = 0; s <= NK; s++) begin
                if (m_pend[s]) begin
                    m_q.push_back(s);
                    m_pend[s] = 1'b0;
                    break;
                end
            end
        end
        m_pend = m_pend | ev;
        m_n    = game_enable ? m_n + 1 : 0;
        m_prev = m_ks;
        for (int k = 0; k < NK; k++) begin
            if (m_s2[k] != m_ks[k]) begin
                m_run[k]++;
                if (m_run[k] == D) begin
                    m_ks[k]  = ~m_ks[k];
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = keys;
    endtask

    task automatic compare_outputs();
        check("frame_tick", 32'(frame_tick), 32'(game_enable && (m_n % P == P - 1)));
        check("int_valid", 32'(int_valid), 32'(m_q.size() != 0));
        check("instr", interrupt_instruction, (m_q.size() != 0) ? word_of(m_q[0]) : 32'd0);
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("key_state", 32'(key_state), 32'(m_ks));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            m_reset();
        end
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int lat;
    bit found;

    initial begin
        do_reset(3);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(int_valid), 32'd0);
        check("rst_instr", interrupt_instruction, 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_keys", 32'(key_state), 32'd0);

        // Frames only, acked as they appear
        game_enable = 1'b1;
        for (int i = 0; i < 45; i++) begin
            int_ack = (m_q.size() != 0);
            step();
        end
        int_ack = 1'b0;

        // Key press latency with an empty queue
        do_reset(1);
        keys[0] = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            lat++;
            if (int_valid) found = 1'b1;
        end
        check("key_latency", 32'(lat), 32'(D + 4));

        // Key press while disabled after the first frame
        keys = '0;
        do_reset(1);
        repeat (10) step();
        game_enable = 1'b0;
        keys[0] = 1'b1;
        repeat (5) step();
        check("ks_before_6", 32'(key_state[0]), 32'd0);
        step();
        check("ks_after_6", 32'(key_state[0]), 32'd1);
        repeat (10) step();
        check("disabled_count", 32'(fifo_count), 32'd1);
        check("disabled_instr", interrupt_instruction, 32'hB000_0000);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;

        // Short glitch on key 1
        game_enable = 1'b1;
        int_ack = 1'b1;
        keys[1] = 1'b1;
        repeat (3) step();
        keys[1] = 1'b0;
        repeat (10) step();
        check("glitch_keys", 32'(key_state), 32'b01);
        int_ack = 1'b0;

        // Saturation, overflow and drain
        keys = '0;
        do_reset(1);
        repeat (60) step();
        check("sat_count", 32'(fifo_count), 32'd4);
        check("sat_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("drain_instr", interrupt_instruction, 32'hB000_0000);
            int_ack = 1'b1;
            step();
        end
        int_ack = 1'b0;
        check("drain_refill", 32'(fifo_count), 32'd1);

        // Key press and frame tick pending together
        do_reset(1);
        repeat (3) step();
        keys[0] = 1'b1;
        repeat (9) step();
        check("tie_count", 32'(fifo_count), 32'd2);
        check("tie_first", interrupt_instruction, 32'hB000_0000);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("tie_second", interrupt_instruction, 32'hB001_0000);

        // Reset with a loaded queue and overflow flagged
        for (int i = 0; i < 100 && !m_ovf; i++) step();
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_valid", 32'(int_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_instr", interrupt_instruction, 32'd0);
        @(posedge clk);
        m_reset();
        #1;
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 7) == 0) keys[k] = ~keys[k];
            end
            game_enable = ($urandom_range(0, 19) != 0);
            int_ack     = ($urandom_range(0, 2) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        int_ack = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
